viterbi_traceback: RTL
======================

Name: viterbi_traceback

Overview:
- Survivor-memory and traceback stage directly downstream of the add-compare-select (ACS) array in the Viterbi decoder.
- Buffers one decision word per trellis step for a frame, then traces back from a given end state.
- Emits the decoded bits in forward (chronological) order over a valid/ready stream to the output pins.
- Frame-based operation, one traceback step per clock.

Parameters:
- K, 3, constraint length; states NS = 2^(K-1).
- MAX_LEN, 32, maximum trellis steps per frame (power of 2).
- AW, $clog2(MAX_LEN), pointer width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  decision word valid.
- in_ready  out  1  block can accept a decision word.
- in_dec  in  NS  survivor decision bit per state; bit s belongs to state s.
- in_last  in  1  this word is the final trellis step of the frame.
- in_best  in  K-1  end state for traceback; sampled with the in_last beat.
- out_valid  out  1  decoded bit valid.
- out_ready  in  1  downstream accepts.
- out_bit  out  1  decoded bit.
- out_last  out  1  final bit of frame.
- busy  out  1  high in TRACE or EMIT.
- overflow  out  1  sticky; frame exceeded MAX_LEN.

Behaviour:
- Trellis convention: next state = {u, s[K-2:1]}; predecessor of s with decision d = {s[K-3:0], d}; decoded bit at state s = s[K-2].
- Reset (async, rst_n=0): FSM=FILL, wptr=0, len=0, in_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0, overflow=0. Memory contents are not reset.
- FILL:
  - in_ready=1.
  - On in_valid&in_ready: mem[wptr]<=in_dec, wptr++.
  - If in_last: tb_state<=in_best, len<=wptr+1, ptr<=wptr, go TRACE.
  - If wptr==MAX_LEN-1 and !in_last: the word is written, overflow<=1, and the beat is treated as last, with tb_state<=in_best.
- TRACE:
  - in_ready=0. One step per cycle.
  - bitbuf[ptr]<=tb_state[K-2]; tb_state<={tb_state[K-3:0], mem[ptr][tb_state]}; ptr--.
  - The step at ptr==0 is the final step; then go EMIT with rptr=0.
- EMIT:
  - out_valid=1, out_bit=bitbuf[rptr], out_last=(rptr==len-1).
  - On out_valid&out_ready: rptr++. On the last beat go FILL, wptr<=0.
  - When out_ready=0, out_bit and out_last are held stable.
- Latency: in_last accepted in cycle t -> TRACE in cycles t+1..t+len -> out_valid first high in cycle t+len+1.
- Single-step frame (len=1): one TRACE cycle, then one output beat with out_last=1.
- Back-to-back frames: the first word of the next frame can be accepted in the cycle after the final output handshake.
- Reset mid-TRACE or mid-EMIT: all outputs go to reset values immediately; the partial frame is discarded.
- overflow is cleared only by reset.
- All outputs are registered except in_ready, which is decoded from FSM state.

Optional Feature:
- Macro: VITERBI_TAIL_STRIP_EN.
- With the macro defined:
  - Frames are zero-terminated, so traceback starts from state 0 and in_best is ignored.
  - The last K-1 decoded bits (the flush tail) are not emitted; out_last marks bit len-K.
  - If len<=K-1, no bits are emitted and the FSM returns to FILL after TRACE.
- Without the macro: traceback starts from in_best and all len bits are emitted.

Decomposition:
- Package viterbi_pkg holds:
  - K, NS, and the state_t typedef (logic [K-2:0]).
  - The tb_fsm_t enum {FILL, TRACE, EMIT}.
  - The shared state-transition functions next_state() and pred_state().
- One sub-module, viterbi_survivor_mem: a MAX_LEN x NS register array with synchronous write and combinational read by (ptr, state).

Test Plan:
- Forward decode, u=1,0,1 from state 00, default build:
  - Stimulus: in_dec=4'b0000, 4'b0000, 4'b0100 (last), in_best=2'b10.
  - Response: out_bit 1,0,1, out_last on the 3rd beat, first out_valid 4 cycles after the in_last beat.
- All-zero frame:
  - Stimulus: 8 words of 4'b0000, in_best=0.
  - Response: 8 zero bits; busy high for 8 TRACE + 8 EMIT cycles.
- Backpressure:
  - Stimulus: same frame as the first scenario, out_ready toggled 0/1 every cycle.
  - Response: same 1,0,1 sequence; out_bit stable while out_ready=0; in_ready stays 0 until the last handshake.
- Overflow:
  - Stimulus: 33 words with in_last never asserted.
  - Response: frame closes at word 32, overflow=1, 32 bits emitted; word 33 is accepted as the first word of the next frame.
- Reset mid-EMIT:
  - Stimulus: rst_n pulsed low after 1 output beat.
  - Response: out_valid=0 and in_ready=1 asynchronously; the next 3-step frame decodes correctly.
- VITERBI_TAIL_STRIP_EN build:
  - Stimulus: u=1,0,1,0,0 encoded from state 00 and terminated.
  - Response: out_bit 1,0,1 with out_last on the 3rd beat; in_best ignored.

Source files
------------

// File: rtl/viterbi_pkg.sv
// -----------------------------------------------------------------------------
// viterbi_pkg
// Shared trellis definitions for the Viterbi traceback block: constraint
// length, state count, the state type, the traceback FSM encoding and the
// state-transition helpers used by both the RTL and anything that models it.
//
// Trellis convention:
//   next state of s on input u    : {u, s[K-2:1]}
//   predecessor of s, decision d  : {s[K-3:0], d}
//   decoded bit carried by state s: s[K-2]
// -----------------------------------------------------------------------------
package viterbi_pkg;

  localparam int K  = 3;
  localparam int NS = 1 << (K - 1);

  typedef logic [K-2:0] state_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    TRACE = 2'd1,
    EMIT  = 2'd2
  } tb_fsm_t;

  function automatic state_t next_state(input state_t s, input logic u);
    return {u, s[K-2:1]};
  endfunction

  function automatic state_t pred_state(input state_t s, input logic d);
    return {s[K-3:0], d};
  endfunction

endpackage

// File: rtl/viterbi_survivor_mem.sv
// -----------------------------------------------------------------------------
// viterbi_survivor_mem
// Survivor memory: MAX_LEN words of NS decision bits. Synchronous write of a
// whole decision word, combinational read of the single decision bit that
// belongs to (row, state). Contents are never reset.
//
// Ports:
//   i_clk     clock
//   i_we      write enable
//   i_waddr   write row (trellis step)
//   i_wdata   decision word, bit s belongs to state s
//   i_raddr   read row
//   i_rstate  state selecting the bit within the read row
//   o_dec     decision bit mem[i_raddr][i_rstate]
// -----------------------------------------------------------------------------
module viterbi_survivor_mem
  import viterbi_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int AW      = $clog2(MAX_LEN)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [NS-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  input  state_t        i_rstate,
  output logic          o_dec
);

  logic [NS-1:0] r_mem [MAX_LEN];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_dec = r_mem[i_raddr][i_rstate];

endmodule

// File: rtl/viterbi_traceback.sv
// -----------------------------------------------------------------------------
// viterbi_traceback
// Survivor-memory and traceback stage behind the ACS array. Buffers one
// decision word per trellis step (FILL), traces back one step per clock from
// the end state (TRACE), then streams the decoded bits out in chronological
// order over valid/ready (EMIT).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     decision word valid
//   in_ready     block accepts a decision word (FILL state)
//   in_dec       decision bit per state
//   in_last      final trellis step of the frame
//   in_best      traceback end state, sampled with the in_last beat
//   out_valid    decoded bit valid
//   out_ready    downstream accepts
//   out_bit      decoded bit
//   out_last     final decoded bit of the frame
//   busy         high while in TRACE or EMIT
//   overflow     sticky: a frame ran past MAX_LEN words
//
// Build option VITERBI_TAIL_STRIP_EN: frames are zero-terminated, traceback
// starts from state 0 (in_best ignored) and the K-1 flush-tail bits are not
// emitted. Frames of K-1 steps or fewer emit nothing.
// -----------------------------------------------------------------------------
module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int AW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NS-1:0] in_dec,
  input  logic          in_last,
  input  logic [K-2:0]  in_best,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          out_last,
  output logic          busy,
  output logic          overflow
);

  tb_fsm_t            r_state;
  tb_fsm_t            w_state_nxt;
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_ptr;
  logic [AW-1:0]      r_rptr;
  logic [AW:0]        r_len;
  logic [AW:0]        w_emit_cnt;
  state_t             r_tb_state;
  state_t             w_start_state;
  logic [MAX_LEN-1:0] r_bitbuf;
  logic               r_out_valid;
  logic               r_out_bit;
  logic               r_out_last;
  logic               r_busy;
  logic               r_overflow;
  logic               w_in_ready;
  logic               w_in_fire;
  logic               w_wrap;
  logic               w_close;
  logic               w_trace_done;
  logic               w_out_fire;
  logic               w_dec;
  logic [AW-1:0]      w_rptr_inc;

  assign w_in_ready   = (r_state == FILL);
  assign w_in_fire    = in_valid & w_in_ready;
  assign w_wrap       = (r_wptr == AW'(MAX_LEN - 1));
  // A full buffer closes the frame even without in_last.
  assign w_close      = w_in_fire & (in_last | w_wrap);
  assign w_trace_done = (r_state == TRACE) && (r_ptr == '0);
  assign w_out_fire   = r_out_valid & out_ready;
  assign w_rptr_inc   = r_rptr + 1'b1;

`ifdef VITERBI_TAIL_STRIP_EN
  logic w_unused_best;
  assign w_unused_best = ^in_best;
  assign w_start_state = '0;
  assign w_emit_cnt    = (r_len > (AW+1)'(K - 1)) ? (r_len - (AW+1)'(K - 1)) : '0;
`else
  assign w_start_state = in_best;
  assign w_emit_cnt    = r_len;
`endif

  // ---- FILL: survivor memory write port ----
  viterbi_survivor_mem #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_mem (
    .i_clk    (clk),
    .i_we     (w_in_fire),
    .i_waddr  (r_wptr),
    .i_wdata  (in_dec),
    .i_raddr  (r_ptr),
    .i_rstate (r_tb_state),
    .o_dec    (w_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FILL:    if (w_close) w_state_nxt = TRACE;
      TRACE:   if (r_ptr == '0) w_state_nxt = (w_emit_cnt == '0) ? FILL : EMIT;
      EMIT:    if (w_out_fire && r_out_last) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  // ---- TRACE/EMIT: pointers and registered output stream ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_ptr       <= '0;
      r_rptr      <= '0;
      r_len       <= '0;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != FILL);

      if (w_in_fire) begin
        if (w_close) begin
          // Write pointer is free again as soon as the frame is closed; the
          // memory is not written again until the FSM is back in FILL.
          r_wptr <= '0;
          r_ptr  <= r_wptr;
          r_len  <= {1'b0, r_wptr} + 1'b1;
        end else begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_wrap && !in_last) begin
          r_overflow <= 1'b1;
        end
      end

      if ((r_state == TRACE) && (r_ptr != '0)) begin
        r_ptr <= r_ptr - 1'b1;
      end

      if (w_trace_done && (w_emit_cnt != '0)) begin
        // bitbuf[0] is being written on this same edge, so bypass it.
        r_out_valid <= 1'b1;
        r_out_bit   <= r_tb_state[K-2];
        r_out_last  <= (w_emit_cnt == (AW+1)'(1));
        r_rptr      <= '0;
      end else if (w_out_fire) begin
        if (r_out_last) begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end else begin
          r_rptr     <= w_rptr_inc;
          r_out_bit  <= r_bitbuf[w_rptr_inc];
          r_out_last <= (({1'b0, w_rptr_inc} + 1'b1) == w_emit_cnt);
        end
      end
    end
  end

  // Traceback datapath: no reset, state is loaded when the frame closes.
  always_ff @(posedge clk) begin
    if (w_close) begin
      r_tb_state <= w_start_state;
    end else if (r_state == TRACE) begin
      r_bitbuf[r_ptr] <= r_tb_state[K-2];
      r_tb_state      <= pred_state(r_tb_state, w_dec);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign overflow  = r_overflow;

endmodule
